// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with valid/ready handshake.
// Each output channel owns a one-entry holding register; steering is by sel or round-robin.
module demux_stream_1ton #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int MODE     = 0,
   localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [SEL_W-1:0]          sel,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [SEL_W-1:0]          rr_ptr,
   output logic [7:0]                drop_cnt
);

   localparam int              PAD_N  = 1 << SEL_W;
   localparam logic [SEL_W:0]   CH_LIM = (SEL_W+1)'(CHANNELS);
   localparam logic [SEL_W-1:0] LAST   = SEL_W'(CHANNELS - 1);

   logic [CHANNELS-1:0]       vld_p0;
   logic [CHANNELS*WIDTH-1:0] data_p0;
   logic [SEL_W-1:0]          rr_p0;
   logic [7:0]                drop_p0;

   logic [SEL_W-1:0]    tgt;
   logic                tgt_ok;
   logic                accept;
   logic [PAD_N-1:0]    free_pad;
   logic [CHANNELS-1:0] load;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] v);
      return (v == LAST) ? '0 : v + 1'b1;
   endfunction

   assign tgt    = (MODE == 1) ? rr_p0 : sel;
   assign tgt_ok = ({1'b0, tgt} < CH_LIM);

   // Padded to a power of two so an out-of-range select indexes a defined bit.
   assign free_pad = PAD_N'(~vld_p0 | out_ready);
   assign in_ready = tgt_ok ? free_pad[tgt] : (MODE == 0);
   assign accept   = in_valid & in_ready;

   always_comb begin
      load = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         load[k] = accept & tgt_ok & (tgt == SEL_W'(k));
      end
   end

   // Stage p0: per-channel holding registers, pointer and drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0  <= '0;
         data_p0 <= '0;
         rr_p0   <= '0;
         drop_p0 <= '0;
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (load[k]) begin
               vld_p0[k]                  <= 1'b1;
               data_p0[k*WIDTH +: WIDTH]  <= in_data;
            end else if (out_ready[k]) begin
               vld_p0[k] <= 1'b0;
            end
         end
         if ((MODE == 1) && accept) begin
            rr_p0 <= rr_next(rr_p0);
         end
         if (accept && !tgt_ok) begin
            drop_p0 <= sat_inc(drop_p0);
         end
      end
   end

   assign out_valid = vld_p0;
   assign out_data  = data_p0;
   assign rr_ptr    = rr_p0;
   assign drop_cnt  = drop_p0;

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed and scoreboard bench for demux_stream_1ton across several parameter sets.
module tb_demux_stream_1ton;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // u0: WIDTH 8, CHANNELS 4, MODE 0
   logic        d0_iv, d0_ir;
   logic [7:0]  d0_id;
   logic [1:0]  d0_sel;
   logic [3:0]  d0_ov, d0_or;
   logic [31:0] d0_od;
   logic [1:0]  d0_rr;
   logic [7:0]  d0_dc;

   // u3: WIDTH 8, CHANNELS 3, MODE 0
   logic        d3_iv, d3_ir;
   logic [7:0]  d3_id;
   logic [1:0]  d3_sel;
   logic [2:0]  d3_ov, d3_or;
   logic [23:0] d3_od;
   logic [1:0]  d3_rr;
   logic [7:0]  d3_dc;

   // u1: WIDTH 8, CHANNELS 4, MODE 1
   logic        d1_iv, d1_ir;
   logic [7:0]  d1_id;
   logic [1:0]  d1_sel;
   logic [3:0]  d1_ov, d1_or;
   logic [31:0] d1_od;
   logic [1:0]  d1_rr;
   logic [7:0]  d1_dc;

   demux_stream_1ton #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(d0_iv), .in_ready(d0_ir), .in_data(d0_id),
      .sel(d0_sel), .out_valid(d0_ov), .out_ready(d0_or), .out_data(d0_od),
      .rr_ptr(d0_rr), .drop_cnt(d0_dc));

   demux_stream_1ton #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u3 (
      .clk(clk), .rst(rst), .in_valid(d3_iv), .in_ready(d3_ir), .in_data(d3_id),
      .sel(d3_sel), .out_valid(d3_ov), .out_ready(d3_or), .out_data(d3_od),
      .rr_ptr(d3_rr), .drop_cnt(d3_dc));

   demux_stream_1ton #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(d1_iv), .in_ready(d1_ir), .in_data(d1_id),
      .sel(d1_sel), .out_valid(d1_ov), .out_ready(d1_or), .out_data(d1_od),
      .rr_ptr(d1_rr), .drop_cnt(d1_dc));

   // Sweep instances: (32,5,0), (1,16,1), (8,2,0)
   int cw[3] = '{32, 1, 8};
   int cc[3] = '{5, 16, 2};
   int cm[3] = '{0, 1, 0};

   logic        sw_iv[3];
   logic [31:0] sw_id[3];
   logic [3:0]  sw_sel[3];
   logic [15:0] sw_or[3];
   logic        sw_ir[3];
   logic [15:0] sw_ov[3];
   logic [511:0] sw_od[3];
   logic [3:0]  sw_rr[3];
   logic [7:0]  sw_dc[3];

   logic         s0_ir, s1_ir, s2_ir;
   logic [4:0]   s0_ov;
   logic [15:0]  s1_ov;
   logic [1:0]   s2_ov;
   logic [159:0] s0_od;
   logic [15:0]  s1_od;
   logic [15:0]  s2_od;
   logic [2:0]   s0_rr;
   logic [3:0]   s1_rr;
   logic [0:0]   s2_rr;
   logic [7:0]   s0_dc, s1_dc, s2_dc;

   demux_stream_1ton #(.WIDTH(32), .CHANNELS(5), .MODE(0)) s0 (
      .clk(clk), .rst(rst), .in_valid(sw_iv[0]), .in_ready(s0_ir), .in_data(sw_id[0][31:0]),
      .sel(sw_sel[0][2:0]), .out_valid(s0_ov), .out_ready(sw_or[0][4:0]), .out_data(s0_od),
      .rr_ptr(s0_rr), .drop_cnt(s0_dc));

   demux_stream_1ton #(.WIDTH(1), .CHANNELS(16), .MODE(1)) s1 (
      .clk(clk), .rst(rst), .in_valid(sw_iv[1]), .in_ready(s1_ir), .in_data(sw_id[1][0:0]),
      .sel(sw_sel[1][3:0]), .out_valid(s1_ov), .out_ready(sw_or[1][15:0]), .out_data(s1_od),
      .rr_ptr(s1_rr), .drop_cnt(s1_dc));

   demux_stream_1ton #(.WIDTH(8), .CHANNELS(2), .MODE(0)) s2 (
      .clk(clk), .rst(rst), .in_valid(sw_iv[2]), .in_ready(s2_ir), .in_data(sw_id[2][7:0]),
      .sel(sw_sel[2][0:0]), .out_valid(s2_ov), .out_ready(sw_or[2][1:0]), .out_data(s2_od),
      .rr_ptr(s2_rr), .drop_cnt(s2_dc));

   always_comb begin
      sw_ir[0] = s0_ir;          sw_ir[1] = s1_ir;          sw_ir[2] = s2_ir;
      sw_ov[0] = 16'(s0_ov);     sw_ov[1] = s1_ov;          sw_ov[2] = 16'(s2_ov);
      sw_od[0] = 512'(s0_od);    sw_od[1] = 512'(s1_od);    sw_od[2] = 512'(s2_od);
      sw_rr[0] = 4'(s0_rr);      sw_rr[1] = s1_rr;          sw_rr[2] = 4'(s2_rr);
      sw_dc[0] = s0_dc;          sw_dc[1] = s1_dc;          sw_dc[2] = s2_dc;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] sq[3][16][$];
   int          rr_m[3];
   int          n_acc[3];
   int          n_del[3];

   task automatic run_sweep(input int cycles);
      logic [31:0] mask;
      logic [31:0] got;
      int          t;
      logic        acc;
      logic        exp_ir;
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 16; k++) sq[i][k].delete();
         rr_m[i] = 0; n_acc[i] = 0; n_del[i] = 0;
      end
      for (int c = 0; c < cycles; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (c < cycles - 40) begin
               sw_iv[i]  = ($urandom_range(0, 3) != 0);
               sw_sel[i] = 4'($urandom_range(0, (cc[i] == 5) ? 6 : cc[i] - 1));
               sw_or[i]  = 16'($urandom);
            end else begin
               sw_iv[i]  = 1'b0;
               sw_sel[i] = '0;
               sw_or[i]  = 16'hFFFF;
            end
            sw_id[i] = $urandom;
         end
         #1;
         for (int i = 0; i < 3; i++) begin
            mask = (cw[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw[i]) - 32'd1);
            for (int k = 0; k < cc[i]; k++) begin
               chk($sformatf("sw%0d_vld%0d", i, k), 64'(sw_ov[i][k]), 64'(sq[i][k].size() != 0));
               if (sw_ov[i][k] && sq[i][k].size() != 0) begin
                  got = 32'(sw_od[i] >> (k * cw[i])) & mask;
                  chk($sformatf("sw%0d_dat%0d", i, k), 64'(got), 64'(sq[i][k][0]));
               end
            end
            chk($sformatf("sw%0d_rr", i), 64'(sw_rr[i]), 64'((cm[i] == 1) ? rr_m[i] : 0));
            t = (cm[i] == 1) ? rr_m[i] : int'(sw_sel[i]);
            exp_ir = (t < cc[i]) ? ((sq[i][t].size() == 0) || sw_or[i][t]) : 1'b1;
            chk($sformatf("sw%0d_ir", i), 64'(sw_ir[i]), 64'(exp_ir));
            acc = sw_iv[i] & sw_ir[i];
            for (int k = 0; k < cc[i]; k++) begin
               if (sw_ov[i][k] && sw_or[i][k] && sq[i][k].size() != 0) begin
                  void'(sq[i][k].pop_front());
                  n_del[i]++;
               end
            end
            if (acc && t < cc[i]) begin
               sq[i][t].push_back(sw_id[i] & mask);
               n_acc[i]++;
               if (cm[i] == 1) rr_m[i] = (rr_m[i] + 1) % cc[i];
            end
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("sw%0d_delivered", i), 64'(n_del[i]), 64'(n_acc[i]));
         chk($sformatf("sw%0d_active", i), 64'(n_acc[i] > 20), 64'(1));
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1;
      d0_iv = 0; d0_id = 0; d0_sel = 0; d0_or = 4'hF;
      d3_iv = 0; d3_id = 0; d3_sel = 0; d3_or = 3'h7;
      d1_iv = 0; d1_id = 0; d1_sel = 0; d1_or = 4'hF;
      for (int i = 0; i < 3; i++) begin
         sw_iv[i] = 0; sw_id[i] = 0; sw_sel[i] = 0; sw_or[i] = 0;
      end
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_ov", 64'(d0_ov), 64'h0);
      chk("rst_od", 64'(d0_od), 64'h0);
      chk("rst_rr", 64'(d1_rr), 64'h0);
      chk("rst_dc", 64'(d0_dc), 64'h0);
      chk("rst_ir", 64'(d0_ir), 64'h1);

      // select-driven streaming, all consumers ready
      for (int i = 0; i < 4; i++) begin
         d0_iv = 1; d0_id = 8'(8'h11 * (i + 1)); d0_sel = 2'(i);
         #1; chk("t1_ir", 64'(d0_ir), 64'h1);
         tick();
         chk("t1_ov", 64'(d0_ov), 64'(4'b1 << i));
         chk("t1_od", 64'(d0_od[i*8 +: 8]), 64'(8'h11 * (i + 1)));
      end
      d0_iv = 0;
      tick();
      chk("t1_drain", 64'(d0_ov), 64'h0);
      chk("t1_hold", 64'(d0_od[31:24]), 64'h44);

      // stalled channel 2 back-pressures only beats aimed at it
      d0_or = 4'b1011;
      d0_iv = 1; d0_id = 8'hA5; d0_sel = 2;
      #1; chk("t2_ir_a", 64'(d0_ir), 64'h1);
      tick();
      chk("t2_ov_a", 64'(d0_ov), 64'b0100);
      chk("t2_od_a", 64'(d0_od[23:16]), 64'hA5);
      d0_id = 8'h5A;
      #1; chk("t2_ir_stall", 64'(d0_ir), 64'h0);
      tick();
      chk("t2_ov_stall", 64'(d0_ov), 64'b0100);
      chk("t2_od_stall", 64'(d0_od[23:16]), 64'hA5);
      d0_id = 8'h77; d0_sel = 1;
      #1; chk("t2_ir_ch1", 64'(d0_ir), 64'h1);
      tick();
      chk("t2_ov_ch1", 64'(d0_ov), 64'b0110);
      chk("t2_od_ch1", 64'(d0_od[15:8]), 64'h77);
      d0_or = 4'b1111; d0_id = 8'h5A; d0_sel = 2;
      #1; chk("t2_ir_pass", 64'(d0_ir), 64'h1);
      tick();
      chk("t2_ov_pass", 64'(d0_ov), 64'b0100);
      chk("t2_od_pass", 64'(d0_od[23:16]), 64'h5A);
      d0_iv = 0;
      tick();
      chk("t2_ov_end", 64'(d0_ov), 64'h0);
      chk("t2_od_keep", 64'(d0_od[23:16]), 64'h5A);

      // out-of-range select on a 3-channel block
      d3_iv = 1; d3_sel = 3; d3_id = 8'hEE;
      #1; chk("t3_ir", 64'(d3_ir), 64'h1);
      tick();
      chk("t3_dc1", 64'(d3_dc), 64'd1);
      chk("t3_ov1", 64'(d3_ov), 64'h0);
      repeat (299) tick();
      chk("t3_dc_sat", 64'(d3_dc), 64'd255);
      chk("t3_ov_end", 64'(d3_ov), 64'h0);
      d3_iv = 0;

      // round-robin order
      for (int i = 0; i < 6; i++) begin
         d1_iv = 1; d1_id = 8'(8'h10 + i);
         #1; chk("t4_ir", 64'(d1_ir), 64'h1);
         tick();
         chk("t4_ov", 64'(d1_ov), 64'(4'b1 << (i % 4)));
         chk("t4_od", 64'(d1_od[(i%4)*8 +: 8]), 64'(8'h10 + i));
      end
      chk("t4_rr", 64'(d1_rr), 64'd2);
      d1_iv = 0;
      tick();
      d1_or = 4'b1101;
      for (int j = 0; j < 7; j++) begin
         d1_iv = 1; d1_id = 8'(8'hC0 + ((j + 2) % 4) + ((j >= 4) ? 4 : 0));
         #1; chk("t4_ir_fill", 64'(d1_ir), 64'h1);
         tick();
      end
      chk("t4_rr_at1", 64'(d1_rr), 64'd1);
      chk("t4_hold_c1", 64'(d1_od[15:8]), 64'hC1);
      d1_id = 8'hC7;
      #1; chk("t4_ir_stall", 64'(d1_ir), 64'h0);
      tick();
      chk("t4_rr_hold", 64'(d1_rr), 64'd1);
      chk("t4_ov1_hold", 64'(d1_ov[1]), 64'h1);
      tick();
      chk("t4_rr_hold2", 64'(d1_rr), 64'd1);
      d1_or = 4'b1111;
      #1; chk("t4_ir_go", 64'(d1_ir), 64'h1);
      tick();
      chk("t4_od_c7", 64'(d1_od[15:8]), 64'hC7);
      chk("t4_ov1_c7", 64'(d1_ov[1]), 64'h1);
      chk("t4_rr_adv", 64'(d1_rr), 64'd2);

      // reset while channels hold beats
      d1_or = 4'b0000;
      for (int j = 0; j < 3; j++) begin
         d1_iv = 1; d1_id = 8'(8'hD0 + j);
         #1; chk("t5_ir_fill", 64'(d1_ir), 64'h1);
         tick();
      end
      chk("t5_ov_full", 64'(d1_ov), 64'hF);
      d1_iv = 1; d1_id = 8'hEE;
      d0_iv = 1; d0_id = 8'h99; d0_sel = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0; d1_iv = 0; d0_iv = 0;
      #1;
      chk("t5_ov", 64'(d1_ov), 64'h0);
      chk("t5_od", 64'(d1_od), 64'h0);
      chk("t5_rr", 64'(d1_rr), 64'h0);
      chk("t5_dc", 64'(d3_dc), 64'h0);
      chk("t5_u0_ov", 64'(d0_ov), 64'h0);
      chk("t5_u0_od", 64'(d0_od), 64'h0);
      tick();
      chk("t5_u0_nodel", 64'(d0_ov), 64'h0);
      chk("t5_u1_nodel", 64'(d1_ov), 64'h0);

      // random valid/ready across parameter sets
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run_sweep(600);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
